// File: rtl/btnc_select_sequencer_pkg.sv
// Shared types and helpers for the button-driven demux front end.
// Holds the pulse FSM states, the pending-step encoding and the channel arithmetic.
package btn_seq_pkg;

  localparam int NUM_CHANNELS = 4;
  localparam int SEL_W        = $clog2(NUM_CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } pulse_state_t;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_UP   = 2'd1,
    PEND_DOWN = 2'd2
  } pend_t;

  // Channel step with natural wrap: NUM_CHANNELS is a power of two.
  function automatic logic [SEL_W-1:0] sel_step(input logic [SEL_W-1:0] cur,
                                                input logic             up);
    logic [SEL_W-1:0] nxt;
    if (up) nxt = cur + SEL_W'(1);
    else    nxt = cur - SEL_W'(1);
    return nxt;
  endfunction

endpackage

// File: rtl/btnc_select_sequencer_if.sv
// Button inputs and demux-facing outputs of the select sequencer.
// master = board/stimulus side, slave = sequencer side.
interface btnc_select_sequencer_if;

  logic                        btnC_raw;
  logic                        btnL_raw;
  logic                        btnR_raw;
  logic                        sw_mode;
  logic                        data;
  logic [btn_seq_pkg::SEL_W-1:0] sel;
  logic                        busy;

  modport master (
    output btnC_raw,
    output btnL_raw,
    output btnR_raw,
    output sw_mode,
    input  data,
    input  sel,
    input  busy
  );

  modport slave (
    input  btnC_raw,
    input  btnL_raw,
    input  btnR_raw,
    input  sw_mode,
    output data,
    output sel,
    output busy
  );

endinterface

// File: rtl/btnc_select_sequencer_debounce.sv
// Per-button synchroniser and debouncer producing a clean level and a one-cycle rise pulse.
// The level flips only after the synchronised input disagrees with it for DEBOUNCE_CYCLES cycles.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_level_q;
  logic                   r_rise;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
    end
  end

  // Counter holds 0..DEBOUNCE_CYCLES-1; the last disagreeing cycle flips the level.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync != r_level) begin
      if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_level_q <= 1'b0;
      r_rise    <= 1'b0;
    end else begin
      r_level_q <= r_level;
      r_rise    <= r_level & ~r_level_q;
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/btnc_select_sequencer.sv
// Drives the 1-to-4 enable demux: debounced btnC becomes data (level or pulse),
// btnL/btnR step sel, and sel is frozen while data is high so the enable never hops channels.
module btnc_select_sequencer
  import btn_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int PULSE_CYCLES    = 1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  btnc_select_sequencer_if.slave  bus
);

  localparam int PCNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic              w_lvlC;
  logic              w_riseC;
  logic              w_riseL;
  logic              w_riseR;
  logic [1:0]        w_unused_lvl;

  logic              w_req_up;
  logic              w_req_dn;

  pulse_state_t      r_state;
  pulse_state_t      w_state_nxt;
  logic [PCNT_W-1:0] r_cnt;
  logic [PCNT_W-1:0] w_cnt_nxt;
  logic              w_data_nxt;
  logic              r_data;
  logic              r_busy;
  logic              r_mode_q;
  logic [SEL_W-1:0]  r_sel;
  pend_t             r_pend;

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_c (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btnC_raw),
    .level (w_lvlC),
    .rise  (w_riseC)
  );

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_l (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btnL_raw),
    .level (w_unused_lvl[0]),
    .rise  (w_riseL)
  );

  btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_deb_r (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.btnR_raw),
    .level (w_unused_lvl[1]),
    .rise  (w_riseR)
  );

  // Opposing requests in the same cycle cancel and are dropped.
  assign w_req_up = w_riseR & ~w_riseL;
  assign w_req_dn = w_riseL & ~w_riseR;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = 1'b0;
    if (!bus.sw_mode) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_data_nxt  = w_lvlC;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // Entering pulse mode with btnC already held: swallow this press.
          if (!r_mode_q && w_lvlC) begin
            w_state_nxt = ST_HOLD;
          end else if (w_riseC) begin
            w_state_nxt = ST_PULSE;
            w_cnt_nxt   = '0;
            w_data_nxt  = 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == PCNT_W'(PULSE_CYCLES - 1)) begin
            w_state_nxt = ST_HOLD;
            w_data_nxt  = 1'b0;
          end else begin
            w_cnt_nxt  = r_cnt + PCNT_W'(1);
            w_data_nxt = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_lvlC) w_state_nxt = ST_IDLE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_data   <= 1'b0;
      r_busy   <= 1'b0;
      r_mode_q <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_data   <= w_data_nxt;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_mode_q <= bus.sw_mode;
    end
  end

  // A fresh request beats a stored one; the store is emptied whenever data is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel  <= '0;
      r_pend <= PEND_NONE;
    end else if (!r_data) begin
      if (w_req_up || w_req_dn) begin
        r_sel <= sel_step(r_sel, w_req_up);
      end else if (r_pend != PEND_NONE) begin
        r_sel <= sel_step(r_sel, r_pend == PEND_UP);
      end
      r_pend <= PEND_NONE;
    end else if (w_req_up) begin
      r_pend <= PEND_UP;
    end else if (w_req_dn) begin
      r_pend <= PEND_DOWN;
    end
  end

  assign bus.data = r_data;
  assign bus.sel  = r_sel;
  assign bus.busy = r_busy;

endmodule
